// File: rtl/spi_pkg.sv
// Shared command codes, FSM state encoding and mode bit positions for the SPI master.
package spi_pkg;

  localparam logic [2:0] SPI_XFER       = 3'd0;
  localparam logic [2:0] SPI_INIT       = 3'd1;
  localparam logic [2:0] SPI_CS_ASSERT  = 3'd2;
  localparam logic [2:0] SPI_CS_RELEASE = 3'd3;
  localparam logic [2:0] SPI_WAIT_RESP  = 3'd4;

  // spi_mode is {CPOL, CPHA}
  localparam int MODE_CPOL = 1;
  localparam int MODE_CPHA = 0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CSOP,
    ST_INIT,
    ST_SHIFT,
    ST_WAITR
  } spi_state_t;

endpackage

// File: rtl/spi_master_mc_shifter.sv
// SCLK generator and MSB-first shift engine shared by XFER, INIT and WAIT_RESP.
// A half-period counter runs 0..div; every wrap is one SCLK edge. Even edge
// indices are leading edges, odd ones trailing.
module spi_shifter
  import spi_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int DIV_W       = 8,
  parameter int INIT_CLOCKS = 80
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              start,
  input  logic              restart,
  input  logic              init,
  input  logic [1:0]        mode,
  input  logic [DIV_W-1:0]  div,
  input  logic [DATA_W-1:0] word,
  input  logic              miso,
  output logic              sclk,
  output logic              mosi,
  output logic              done,
  output logic [DATA_W-1:0] rx_word
);

  localparam int MAX_BITS = (DATA_W > INIT_CLOCKS) ? DATA_W : INIT_CLOCKS;
  localparam int EDGE_W   = $clog2(2 * MAX_BITS);
  localparam logic [EDGE_W-1:0] LAST_XFER = EDGE_W'(2 * DATA_W - 1);
  localparam logic [EDGE_W-1:0] LAST_INIT = EDGE_W'(2 * INIT_CLOCKS - 1);

  logic              active;
  logic              cpol_q;
  logic              cpha_q;
  logic              init_q;
  logic [DIV_W-1:0]  div_q;
  logic [DIV_W-1:0]  half_cnt;
  logic [EDGE_W-1:0] edge_cnt;
  logic [DATA_W-1:0] tx;
  logic [DATA_W-1:0] rx;
  logic              edge_now;
  logic              leading;
  logic              sample_edge;
  logic              shift_edge;

  // Edge classification; the word seen on the final edge includes that edge's sample
  always_comb begin
    edge_now    = active && (half_cnt == div_q);
    leading     = ~edge_cnt[0];
    sample_edge = edge_now && (leading != cpha_q);
    shift_edge  = edge_now && (leading == cpha_q);
    done        = edge_now && (edge_cnt == (init_q ? LAST_INIT : LAST_XFER));
    rx_word     = sample_edge ? {rx[DATA_W-2:0], miso} : rx;
  end

  // Load on start/restart, then toggle SCLK and shift on each half-period wrap
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      active   <= 1'b0;
      cpol_q   <= 1'b0;
      cpha_q   <= 1'b0;
      init_q   <= 1'b0;
      div_q    <= '0;
      half_cnt <= '0;
      edge_cnt <= '0;
      tx       <= '1;
      rx       <= '1;
      sclk     <= 1'b0;
      mosi     <= 1'b1;
    end else if (start) begin
      active   <= 1'b1;
      cpol_q   <= mode[MODE_CPOL];
      cpha_q   <= mode[MODE_CPHA];
      init_q   <= init;
      div_q    <= div;
      half_cnt <= '0;
      edge_cnt <= '0;
      rx       <= '1;
      sclk     <= mode[MODE_CPOL];
      if (init) begin
        tx   <= '1;
        mosi <= 1'b1;
      end else begin
        // CPHA=0 already presents the MSB, so the register holds the rest
        tx   <= mode[MODE_CPHA] ? word : {word[DATA_W-2:0], 1'b1};
        mosi <= word[DATA_W-1];
      end
    end else if (restart) begin
      // Back-to-back all-ones word for response polling, same clocking setup
      active   <= 1'b1;
      half_cnt <= '0;
      edge_cnt <= '0;
      rx       <= '1;
      tx       <= '1;
      mosi     <= 1'b1;
      sclk     <= cpol_q;
    end else if (active) begin
      if (edge_now) begin
        half_cnt <= '0;
        edge_cnt <= edge_cnt + 1'b1;
        sclk     <= ~sclk;
        if (sample_edge) rx <= {rx[DATA_W-2:0], miso};
        if (shift_edge) begin
          mosi <= tx[DATA_W-1];
          tx   <= {tx[DATA_W-2:0], 1'b1};
        end
        if (done) active <= 1'b0;
      end else begin
        half_cnt <= half_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/spi_master_mc.sv
// Multi-chip-select SPI master: command FSM, chip-select register, response
// polling word counter and timeout flag around the shared shift engine.
module spi_master_mc
  import spi_pkg::*;
#(
  parameter int DATA_W        = 8,
  parameter int CS_COUNT      = 2,
  parameter int DIV_W         = 8,
  parameter int INIT_CLOCKS   = 80,
  parameter int TIMEOUT_WORDS = 256,
  localparam int CSEL_W       = (CS_COUNT > 1) ? $clog2(CS_COUNT) : 1
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                spi_signal,
  input  logic [2:0]          spi_cmd,
  input  logic [DATA_W-1:0]   spi_out,
  input  logic [CSEL_W-1:0]   spi_csel,
  input  logic [DIV_W-1:0]    spi_div,
  input  logic [1:0]          spi_mode,
  output logic [DATA_W-1:0]   spi_din,
  output logic                spi_busy,
  output logic                spi_timeout,
  output logic [CS_COUNT-1:0] SPI_CS,
  output logic                SPI_SCLK,
  input  logic                SPI_MISO,
  output logic                SPI_MOSI
);

  localparam int WCNT_W = $clog2(TIMEOUT_WORDS + 1);
  localparam logic [WCNT_W-1:0] WCNT_MAX = WCNT_W'(TIMEOUT_WORDS);
  localparam logic [DATA_W-1:0] ONES = '1;

  spi_state_t          state;
  spi_state_t          state_n;
  logic                accept;
  logic                sh_start;
  logic                sh_restart;
  logic                sh_init;
  logic                sh_done;
  logic [DATA_W-1:0]   sh_rx;
  logic [DATA_W-1:0]   sh_word;
  logic [WCNT_W-1:0]   wcnt;
  logic [WCNT_W-1:0]   wcnt_inc;
  logic                resp_hit;
  logic                word_last;
  logic [CS_COUNT-1:0] cs_dec;

  assign accept    = (state == ST_IDLE) && spi_signal;
  assign spi_busy  = (state != ST_IDLE);
  assign sh_word   = (spi_cmd == SPI_WAIT_RESP) ? ONES : spi_out;
  assign wcnt_inc  = (wcnt == WCNT_MAX) ? wcnt : wcnt + 1'b1;
  assign resp_hit  = (sh_rx != ONES);
  assign word_last = (wcnt_inc == WCNT_MAX);

  // Chip-select decode; an out-of-range select matches nothing and releases all
  always_comb begin
    cs_dec = '1;
    for (int i = 0; i < CS_COUNT; i++) begin
      if (spi_csel == CSEL_W'(i)) cs_dec[i] = 1'b0;
    end
  end

  // FSM state register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_n;
  end

  // Next state and shifter control
  always_comb begin
    state_n    = state;
    sh_start   = 1'b0;
    sh_restart = 1'b0;
    sh_init    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (spi_signal) begin
          case (spi_cmd)
            SPI_XFER: begin
              sh_start = 1'b1;
              state_n  = ST_SHIFT;
            end
            SPI_INIT: begin
              sh_start = 1'b1;
              sh_init  = 1'b1;
              state_n  = ST_INIT;
            end
            SPI_CS_ASSERT, SPI_CS_RELEASE: state_n = ST_CSOP;
            SPI_WAIT_RESP: begin
              sh_start = 1'b1;
              state_n  = ST_WAITR;
            end
            default: ;
          endcase
        end
      end
      ST_CSOP: state_n = ST_IDLE;
      ST_INIT, ST_SHIFT: begin
        if (sh_done) state_n = ST_IDLE;
      end
      ST_WAITR: begin
        if (sh_done) begin
          if (resp_hit || word_last) state_n    = ST_IDLE;
          else                       sh_restart = 1'b1;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // Chip selects, received word, timeout flag and polling word counter
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      SPI_CS      <= '1;
      spi_din     <= '1;
      spi_timeout <= 1'b0;
      wcnt        <= '0;
    end else begin
      if (accept) begin
        case (spi_cmd)
          SPI_CS_ASSERT:            SPI_CS <= cs_dec;
          SPI_CS_RELEASE, SPI_INIT: SPI_CS <= '1;
          SPI_WAIT_RESP: begin
            spi_timeout <= 1'b0;
            wcnt        <= '0;
          end
          default: ;
        endcase
      end
      if (state == ST_SHIFT && sh_done) spi_din <= sh_rx;
      if (state == ST_WAITR && sh_done) begin
        wcnt <= wcnt_inc;
        if (resp_hit) begin
          spi_din     <= sh_rx;
          spi_timeout <= 1'b0;
        end else if (word_last) begin
          spi_din     <= ONES;
          spi_timeout <= 1'b1;
        end
      end
    end
  end

  spi_shifter #(
    .DATA_W      (DATA_W),
    .DIV_W       (DIV_W),
    .INIT_CLOCKS (INIT_CLOCKS)
  ) u_shifter (
    .clock   (clock),
    .reset_n (reset_n),
    .start   (sh_start),
    .restart (sh_restart),
    .init    (sh_init),
    .mode    (spi_mode),
    .div     (spi_div),
    .word    (sh_word),
    .miso    (SPI_MISO),
    .sclk    (SPI_SCLK),
    .mosi    (SPI_MOSI),
    .done    (sh_done),
    .rx_word (sh_rx)
  );

endmodule

// File: doc/spi_master_mc.md
Name: spi_master_mc

Overview:
- Parametrised SPI master for the AVR SoC port space.
- Successor of the single-device SD SPI unit, with the same strobe/cmd/out and din/busy/timeout style.
- Adds N chip selects, runtime clock divider, all four CPOL/CPHA modes, configurable word width and a hardware response-wait command with timeout.
- Sits behind the CPU port router; port writes generate a one-cycle spi_signal.

Parameters:
- DATA_W, 8: shift word width in bits, MSB first.
- CS_COUNT, 2: number of chip-select outputs.
- DIV_W, 8: width of the clock divider input.
- INIT_CLOCKS, 80: SCLK pulses issued by the INIT command.
- TIMEOUT_WORDS, 256: words clocked by WAIT_RESP before timeout is flagged.

Ports:
- clock  in  1  system clock, all state on posedge.
- reset_n  in  1  asynchronous, active-low reset.
- spi_signal  in  1  one-cycle command strobe.
- spi_cmd  in  3  command code, sampled with spi_signal.
- spi_out  in  DATA_W  transmit word, sampled with spi_signal.
- spi_csel  in  $clog2(CS_COUNT)  target chip select for CS_ASSERT.
- spi_div  in  DIV_W  half-period = spi_div+1 clocks, sampled with spi_signal.
- spi_mode  in  2  {CPOL,CPHA}, sampled with spi_signal.
- spi_din  out  DATA_W  last received word.
- spi_busy  out  1  command in progress.
- spi_timeout  out  1  last WAIT_RESP expired.
- SPI_CS  out  CS_COUNT  active-low chip selects.
- SPI_SCLK  out  1  serial clock.
- SPI_MISO  in  1  serial data in.
- SPI_MOSI  out  1  serial data out.

Behaviour:
- Reset (async, reset_n=0): SPI_CS all ones, SPI_SCLK=0, SPI_MOSI=1, spi_din all ones, spi_busy=0, spi_timeout=0, FSM=IDLE, all counters 0.
- Reset mid-command aborts immediately to the reset values; there is no partial completion.
- Accept rule: spi_signal sampled high in IDLE accepts a command. spi_busy=1 from the next cycle.
- spi_signal while busy is ignored; no queueing.
- On accept, div/mode/out are latched and SPI_SCLK is driven to CPOL the next cycle.
- Commands:
  - 0 XFER: shift DATA_W bits.
  - 1 INIT: all CS high, MOSI=1, INIT_CLOCKS SCLK pulses, spi_din unchanged.
  - 2 CS_ASSERT: SPI_CS[spi_csel]=0, all others 1. Takes 1 cycle busy. spi_csel >= CS_COUNT releases all.
  - 3 CS_RELEASE: all CS high. Takes 1 cycle busy.
  - 4 WAIT_RESP: repeat XFER of all-ones until the received word is not all ones, or until TIMEOUT_WORDS words have been clocked.
  - 5-7: ignored; busy stays 0.
- FSM states: IDLE, CSOP, INIT, SHIFT, WAITR.
  - IDLE -> CSOP (cmd 2,3) -> IDLE.
  - IDLE -> INIT, when INIT_CLOCKS*2 SCLK edges are done -> IDLE.
  - IDLE -> SHIFT, when 2*DATA_W edges are done -> IDLE.
  - IDLE -> WAITR, which loops word-by-word -> IDLE.
- Edge timing: a half-period counter counts 0..div; each wrap toggles SCLK.
  - XFER busy lasts exactly 2*DATA_W*(div+1) cycles.
  - INIT busy lasts 2*INIT_CLOCKS*(div+1) cycles.
- CPHA=0: MOSI presents the MSB in the accept+1 cycle. MISO is sampled on leading edges; MOSI shifts on trailing edges.
- CPHA=1: MOSI shifts on leading edges; MISO is sampled on trailing edges.
- SCLK always ends a command at CPOL.
- spi_din is updated in the same cycle spi_busy falls.
- spi_timeout:
  - Cleared at every WAIT_RESP accept.
  - Set to 1 when word TIMEOUT_WORDS still returns all ones; spi_din is all ones in that case.
  - Set to 0 with the received word in spi_din on an early non-all-ones response.
  - Unchanged by the other commands.
- CS lines are not touched by XFER or WAIT_RESP. The CPU frames transactions explicitly.
- The WAIT_RESP word counter is $clog2(TIMEOUT_WORDS+1) bits wide and saturates; it does not wrap.

Decomposition:
- Package spi_pkg holds the command codes (SPI_XFER=0, SPI_INIT=1, SPI_CS_ASSERT=2, SPI_CS_RELEASE=3, SPI_WAIT_RESP=4), the FSM state enum and the mode bit indices.
- One sub-module, spi_shifter, is natural. It owns the half-period counter, SCLK generation and the DATA_W shift register, and is reused by XFER, INIT and WAIT_RESP.
- spi_master_mc keeps the FSM, CS register, word counter and timeout flag.

Test Plan:
1. Reset held, then released mid-XFER (div=3): outputs go to the reset values immediately; CS all high; next command is accepted normally.
2. MOSI looped to MISO, mode 0, div=0, XFER 0xA5: busy high for exactly 16 cycles, 8 SCLK rising edges, spi_din=0xA5, SCLK ends at 0.
3. Mode 3 (CPOL=1,CPHA=1), div=1, XFER 0x3C, MISO stream 0xC3: SCLK idles at 1, busy 32 cycles, MOSI bits 0,0,1,1,1,1,0,0 on falling edges, spi_din=0xC3.
4. CS_ASSERT csel=1, then CS_RELEASE, then INIT with div=0: SPI_CS=2'b01 after 1 cycle, then 2'b11; INIT gives 80 SCLK pulses with CS all high and MOSI=1; busy 160 cycles.
5. WAIT_RESP with MISO stuck at 1, TIMEOUT_WORDS=4, div=0: busy 64 cycles, spi_timeout=1, spi_din=0xFF. Repeat with MISO returning 0x01 in word 3: busy 48 cycles, timeout=0, spi_din=0x01.
6. spi_signal pulsed during busy and cmd=6 pulsed in IDLE: both ignored; the in-flight word completes unchanged; busy stays 0 for cmd 6.
